// File: rtl/sync_serial_tx.sv
// Synchronous serial link framer: divides clk into data_clk and
// shifts one parallel frame out under an Enable qualifier.
module sync_serial_tx #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              data_clk,
  output logic              data_point,
  output logic              Enable
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t            state;
  logic [7:0]        div;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_next;
  logic              wrap;

  assign wrap = (div == 8'(CLK_DIV - 1));

  function automatic logic first_bit(
    input logic [DATA_W-1:0] v
  );
    if (MSB_FIRST != 0) return v[DATA_W-1];
    else return v[0];
  endfunction

  always_comb begin
    sr_next = sr;
    if (MSB_FIRST != 0) sr_next = sr << 1;
    else sr_next = sr >> 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_clk   <= 1'b0;
      data_point <= 1'b0;
      Enable     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr         <= data_in;
            data_point <= first_bit(data_in);
            Enable     <= 1'b1;
            busy       <= 1'b1;
            div        <= '0;
            bit_cnt    <= '0;
            data_clk   <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          div <= wrap ? 8'd0 : div + 8'd1;
          if (wrap) begin
            data_clk <= ~data_clk;
            // rise: receiver samples; fall: next bit or frame end
            if (!data_clk) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt == CNT_W'(DATA_W)) begin
              Enable     <= 1'b0;
              data_point <= 1'b0;
              done       <= 1'b1;
              state      <= GAP;
            end else begin
              sr         <= sr_next;
              data_point <= first_bit(sr_next);
            end
          end
        end
        GAP: begin
          div <= wrap ? 8'd0 : div + 8'd1;
          if (wrap) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_serial_tx.sv
// Bench for sync_serial_tx: default instance plus an LSB-first
// CLK_DIV=1 instance, checked against a frame-level link model.
module tb_sync_serial_tx;

  logic       clk;
  logic       rst;
  logic [1:0] st;
  logic [7:0] din [2];
  logic [1:0] busy_w, done_w, dc_w, dp_w, en_w;

  int checks = 0;
  int failures = 0;

  int rises [2];
  int en_cnt [2];
  int done_cnt [2];
  int viol [2];
  int since [2];
  int cyc [2];
  int done_cyc [2];
  int lag [2];
  int low_run [2];
  int last_gap [2];
  logic [7:0] bits [2];
  logic [7:0] rx_val [2];
  logic [1:0] pdc, pdp, pen, pbusy;

  sync_serial_tx u0 (
    .clk(clk), .rst(rst), .start(st[0]), .data_in(din[0]),
    .busy(busy_w[0]), .done(done_w[0]), .data_clk(dc_w[0]),
    .data_point(dp_w[0]), .Enable(en_w[0])
  );

  sync_serial_tx #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .data_in(din[1]),
    .busy(busy_w[1]), .done(done_w[1]), .data_clk(dc_w[1]),
    .data_point(dp_w[1]), .Enable(en_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon_step(input int d, input int div);
    cyc[d]++;
    if (dc_w[d] != pdc[d] && !pen[d]) viol[d]++;
    if (dc_w[d] && !en_w[d]) viol[d]++;
    if (dp_w[d] != pdp[d]) begin
      since[d] = 0;
      if (dc_w[d]) viol[d]++;
    end else begin
      since[d]++;
    end
    if (dc_w[d] && !pdc[d]) begin
      rises[d]++;
      bits[d] = {bits[d][6:0], dp_w[d]};
      if (since[d] < div) viol[d]++;
    end
    if (en_w[d]) begin
      en_cnt[d]++;
      if (!pen[d]) last_gap[d] = low_run[d];
      low_run[d] = 0;
    end else begin
      low_run[d]++;
    end
    if (pen[d] && !en_w[d]) rx_val[d] = bits[d];
    if (done_w[d]) begin
      done_cnt[d]++;
      done_cyc[d] = cyc[d];
    end
    if (pbusy[d] && !busy_w[d]) lag[d] = cyc[d] - done_cyc[d];
    pdc[d] = dc_w[d];
    pdp[d] = dp_w[d];
    pen[d] = en_w[d];
    pbusy[d] = busy_w[d];
  endtask

  initial begin
    pdc = '0; pdp = '0; pen = '0; pbusy = '0;
    for (int i = 0; i < 2; i++) begin
      rises[i] = 0; en_cnt[i] = 0; done_cnt[i] = 0; viol[i] = 0;
      since[i] = 0; cyc[i] = 0; done_cyc[i] = 0; lag[i] = -1;
      low_run[i] = 0; last_gap[i] = 0; bits[i] = '0; rx_val[i] = '0;
    end
  end

  always begin
    @(posedge clk);
    #3;
    mon_step(0, 2);
    mon_step(1, 1);
  end

  function automatic logic [7:0] exp_seq(input logic [7:0] v, input bit msb);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[7-i] = msb ? v[7-i] : v[i];
    return s;
  endfunction

  task automatic clear_stats(input int d);
    rises[d] = 0; en_cnt[d] = 0; done_cnt[d] = 0;
    viol[d] = 0; lag[d] = -1; bits[d] = '0;
  endtask

  // Drives one start at the current negedge; returns at the negedge
  // where busy is first seen low after the done pulse.
  task automatic send(input int d, input logic [7:0] data, input bit inject);
    int n;
    bit inj4, injg;
    clear_stats(d);
    st[d] = 1'b1;
    din[d] = data;
    @(negedge clk);
    st[d] = 1'b0;
    din[d] = 8'($urandom);
    n = 0; inj4 = 0; injg = 0;
    while (n < 400 && !(done_cnt[d] > 0 && !busy_w[d])) begin
      st[d] = 1'b0;
      if (inject && rises[d] == 4 && !inj4) begin
        st[d] = 1'b1; din[d] = 8'hFF; inj4 = 1;
      end else if (inject && done_cnt[d] > 0 && !injg) begin
        st[d] = 1'b1; din[d] = 8'hFF; injg = 1;
      end
      @(negedge clk);
      n++;
    end
    st[d] = 1'b0;
    if (n >= 400) chk("frame_timeout", n, 0);
  endtask

  task automatic check_frame(input int d, input logic [7:0] data,
                             input logic [7:0] seq, input int en_clks,
                             input int lag_exp, input bit inject);
    send(d, data, inject);
    chk($sformatf("bits_d%0d_%02h", d, data), int'(bits[d]), int'(seq));
    chk($sformatf("rises_d%0d_%02h", d, data), rises[d], 8);
    chk($sformatf("enable_clks_d%0d_%02h", d, data), en_cnt[d], en_clks);
    chk($sformatf("done_cnt_d%0d_%02h", d, data), done_cnt[d], 1);
    chk($sformatf("busy_lag_d%0d_%02h", d, data), lag[d], lag_exp);
    chk($sformatf("setup_glitch_d%0d_%02h", d, data), viol[d], 0);
    chk($sformatf("rx_value_d%0d_%02h", d, data), int'(rx_val[d]), int'(seq));
  endtask

  typedef struct {
    int         d;
    logic [7:0] data;
    logic [7:0] seq;
    int         en_clks;
    int         lag;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int r, n;
    logic [7:0] v;
    int d;
    tbl[0] = '{0, 8'hA5, 8'hA5, 32, 2};
    tbl[1] = '{0, 8'h3C, 8'h3C, 32, 2};
    tbl[2] = '{0, 8'h00, 8'h00, 32, 2};
    tbl[3] = '{1, 8'h01, 8'h80, 16, 1};
    tbl[4] = '{1, 8'hA5, 8'hA5, 16, 1};

    rst = 1'b0; st = '0; din[0] = '0; din[1] = '0;
    #10;
    chk("reset_d0", int'({busy_w[0], done_w[0], dc_w[0], dp_w[0], en_w[0]}), 0);
    chk("reset_d1", int'({busy_w[1], done_w[1], dc_w[1], dp_w[1], en_w[1]}), 0);
    #5 rst = 1'b1;
    @(negedge clk);

    // reset mid-frame at the third bit
    clear_stats(0);
    st[0] = 1'b1; din[0] = 8'hA5;
    @(negedge clk);
    st[0] = 1'b0;
    n = 0;
    while (rises[0] < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bit3", rises[0], 3);
    #2 rst = 1'b0;
    #1;
    chk("midframe_reset_outs",
        int'({busy_w[0], done_w[0], dc_w[0], dp_w[0], en_w[0]}), 0);
    r = rises[0];
    #14 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("no_edges_in_reset", rises[0], r);
    chk("busy_after_reset", int'(busy_w[0]), 0);
    chk("enable_after_reset", int'(en_w[0]), 0);
    check_frame(0, 8'hA5, 8'hA5, 32, 2, 0);

    for (int i = 0; i < 5; i++) begin
      repeat (3) @(negedge clk);
      check_frame(tbl[i].d, tbl[i].data, tbl[i].seq,
                  tbl[i].en_clks, tbl[i].lag, 0);
    end

    // busy rejection: extra starts at bit 4 and in the gap
    repeat (2) @(negedge clk);
    check_frame(0, 8'h3C, 8'h3C, 32, 2, 1);
    viol[0] = 0;
    repeat (8) @(negedge clk);
    chk("reject_no_new_frame", en_cnt[0], 32);
    chk("reject_done_once", done_cnt[0], 1);
    chk("reject_busy_idle", int'(busy_w[0]), 0);
    chk("idle_no_glitch", viol[0], 0);

    // back-to-back on the first busy-low cycle
    check_frame(0, 8'h81, 8'h81, 32, 2, 0);
    check_frame(0, 8'h7E, 8'h7E, 32, 2, 0);
    chk("b2b_gap_ge_div", int'(last_gap[0] >= 2), 1);
    check_frame(1, 8'h5A, exp_seq(8'h5A, 0), 16, 1, 0);
    check_frame(1, 8'hC3, exp_seq(8'hC3, 0), 16, 1, 0);
    chk("b2b_gap_ge_div_d1", int'(last_gap[1] >= 1), 1);

    for (int i = 0; i < 10; i++) begin
      d = i % 2;
      v = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_frame(d, v, exp_seq(v, d == 0), 2 * (d == 0 ? 2 : 1) * 8,
                  d == 0 ? 2 : 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
